// File: rtl/dual_phase_ramp.sv
// -----------------------------------------------------------------------------
// dual_phase_ramp
//
// Two-phase ramp generator for the PWM comparators. Every period is made of
// two halves of (top_q+1) enabled cycles each:
//   phase A : the high-side ramp counts 0..top_q
//   phase B : split mode    -> the low-side ramp counts 0..top_q
//             triangle mode -> the high-side ramp counts back down top_q..0
// The top value and the mode are sampled only at period boundaries (or on
// clr), so a running period is never disturbed by a mid-period change.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   clock enable; the ramp advances only when en=1
//   clr      in   synchronous restart to phase A / step 0, beats en
//   mode_in  in   0 = split, 1 = triangle (latched at boundary / clr)
//   top_in   in   requested top value (latched at boundary / clr)
//   cnt_h    out  high-side ramp (registered)
//   cnt_l    out  low-side ramp (registered)
//   phase    out  0 = phase A, 1 = phase B (registered)
//   wrap     out  one-cycle pulse on the first cycle of a new period
// -----------------------------------------------------------------------------
module dual_phase_ramp #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_TOP = 180
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             mode_in,
   input  logic [WIDTH-1:0] top_in,
   output logic [WIDTH-1:0] cnt_h,
   output logic [WIDTH-1:0] cnt_l,
   output logic             phase,
   output logic             wrap
);

   typedef enum logic [0:0] {
      PH_A = 1'b0,
      PH_B = 1'b1
   } phase_t;

   localparam logic [WIDTH-1:0] TOP_RST = WIDTH'(DEFAULT_TOP);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO    = '0;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] step_q,  step_d;
   phase_t           phase_q, phase_d;
   logic [WIDTH-1:0] top_q,   top_d;
   logic             mode_q,  mode_d;
   logic [WIDTH-1:0] cnt_h_q, cnt_h_d;
   logic [WIDTH-1:0] cnt_l_q, cnt_l_d;
   logic             wrap_q,  wrap_d;

   // ---------------------------------------------------------------------------
   // Ramp decode: maps (mode, phase, step, top) onto the two ramp outputs.
   // In triangle mode phase B mirrors the step so cnt_h runs top..0; since
   // step never exceeds top the subtraction cannot underflow.
   // ---------------------------------------------------------------------------
   function automatic logic [2*WIDTH-1:0] decode_ramp(
      input logic             tri_mode,
      input phase_t           ph,
      input logic [WIDTH-1:0] stp,
      input logic [WIDTH-1:0] top
   );
      logic [WIDTH-1:0] h;
      logic [WIDTH-1:0] l;
      h = ZERO;
      l = ZERO;
      if (tri_mode) begin
         if (ph == PH_B) begin
            h = top - stp;
         end else begin
            h = stp;
         end
      end else begin
         if (ph == PH_B) begin
            l = stp;
         end else begin
            h = stp;
         end
      end
      return {h, l};
   endfunction

   // Next-state logic for step / phase / latched configuration / wrap pulse.
   always_comb begin
      step_d  = step_q;
      phase_d = phase_q;
      top_d   = top_q;
      mode_d  = mode_q;
      wrap_d  = 1'b0;

      if (clr) begin
         // Restart takes the new configuration immediately and never flags
         // a wrap: the period was cut short, not completed.
         step_d  = ZERO;
         phase_d = PH_A;
         top_d   = top_in;
         mode_d  = mode_in;
      end else if (!en) begin
         // Hold everything; wrap drops so it stays a single-cycle pulse.
         step_d  = step_q;
      end else if (step_q != top_q) begin
         step_d  = step_q + ONE;
      end else begin
         // End of a half. The wrap back to 0 comes from the compare above,
         // so an all-ones top never relies on counter overflow.
         case (phase_q)
            PH_A: begin
               step_d  = ZERO;
               phase_d = PH_B;
            end
            PH_B: begin
               step_d  = ZERO;
               phase_d = PH_A;
               top_d   = top_in;
               mode_d  = mode_in;
               wrap_d  = 1'b1;
            end
            default: begin
               step_d  = ZERO;
               phase_d = PH_A;
            end
         endcase
      end
   end

   // Output decode from the next state, so the registered outputs leave on
   // the same edge as step/phase and already use a freshly latched mode/top.
   always_comb begin
      {cnt_h_d, cnt_l_d} = decode_ramp(mode_d, phase_d, step_d, top_d);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q  <= ZERO;
         phase_q <= PH_A;
         top_q   <= TOP_RST;
         mode_q  <= 1'b0;
         cnt_h_q <= ZERO;
         cnt_l_q <= ZERO;
         wrap_q  <= 1'b0;
      end else begin
         step_q  <= step_d;
         phase_q <= phase_d;
         top_q   <= top_d;
         mode_q  <= mode_d;
         cnt_h_q <= cnt_h_d;
         cnt_l_q <= cnt_l_d;
         wrap_q  <= wrap_d;
      end
   end

   assign cnt_h = cnt_h_q;
   assign cnt_l = cnt_l_q;
   assign phase = phase_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_dual_phase_ramp.sv
module tb_dual_phase_ramp;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic       mode_in;
   logic [7:0] top_in;
   logic [7:0] cnt_h;
   logic [7:0] cnt_l;
   logic       phase;
   logic       wrap;

   int checks   = 0;
   int failures = 0;

   // expected {cnt_h, cnt_l, phase, wrap} after the next rising edge
   logic [17:0] exp_q[$];

   dual_phase_ramp #(.WIDTH(8), .DEFAULT_TOP(180)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .clr     (clr),
      .mode_in (mode_in),
      .top_in  (top_in),
      .cnt_h   (cnt_h),
      .cnt_l   (cnt_l),
      .phase   (phase),
      .wrap    (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expected entry per rising edge while the scoreboard holds any.
   initial begin
      logic [17:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({cnt_h, cnt_l, phase, wrap} !== e) begin
               failures++;
               $display("FAIL ramp t=%0t got h=%0d l=%0d ph=%0d w=%0d exp h=%0d l=%0d ph=%0d w=%0d",
                        $time, cnt_h, cnt_l, phase, wrap, e[17:10], e[9:2], e[1], e[0]);
            end
         end
      end
   end

   // Apply one cycle of inputs and queue the outputs expected after that edge.
   task automatic drive(input logic e, input logic c, input logic m, input logic [7:0] t,
                        input logic [7:0] eh, input logic [7:0] el, input logic ep, input logic ew);
      @(negedge clk);
      en      = e;
      clr     = c;
      mode_in = m;
      top_in  = t;
      exp_q.push_back({eh, el, ep, ew});
   endtask

   task automatic chk(input string name, input logic [17:0] act, input logic [17:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, act, expv);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      en      = 1'b0;
      clr     = 1'b0;
      mode_in = 1'b0;
      top_in  = 8'd180;
      #1;
      chk("reset_state", {cnt_h, cnt_l, phase, wrap}, 18'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("after_release", {cnt_h, cnt_l, phase, wrap}, 18'd0);

      // Default period: top 180, split mode
      for (int i = 1; i <= 180; i++) drive(1'b1, 1'b0, 1'b0, 8'd180, 8'(i), 8'd0, 1'b0, 1'b0);
      for (int j = 0; j <= 180; j++) drive(1'b1, 1'b0, 1'b0, 8'd180, 8'd0, 8'(j), 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd180, 8'd0, 8'd0, 1'b0, 1'b1);

      // Triangle top 3; mode_in switched to split mid-period takes effect at wrap
      drive(1'b0, 1'b1, 1'b1, 8'd3, 8'd0, 8'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 8'd3, 8'd1, 8'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 8'd3, 8'd2, 8'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd3, 8'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd2, 8'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd1, 8'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd0, 8'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd0, 8'd0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd1, 8'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd2, 8'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd0, 8'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd0, 8'd1, 1'b1, 1'b0);

      // Gated enable, top 4: hold on en=0, single-cycle wrap
      drive(1'b1, 1'b1, 1'b0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b0, 1'b0, 8'd4, 8'(i), 8'd0, 1'b0, 1'b0);
         drive(1'b0, 1'b0, 1'b0, 8'd4, 8'(i), 8'd0, 1'b0, 1'b0);
      end
      for (int j = 0; j <= 4; j++) begin
         drive(1'b1, 1'b0, 1'b0, 8'd4, 8'd0, 8'(j), 1'b1, 1'b0);
         drive(1'b0, 1'b0, 1'b0, 8'd4, 8'd0, 8'(j), 1'b1, 1'b0);
      end
      drive(1'b1, 1'b0, 1'b0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd4, 8'd1, 8'd0, 1'b0, 1'b0);

      // top_in 180 -> 5 at step 50: current period still runs to 180
      drive(1'b1, 1'b1, 1'b0, 8'd180, 8'd0, 8'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 50; i++) drive(1'b1, 1'b0, 1'b0, 8'd180, 8'(i), 8'd0, 1'b0, 1'b0);
      for (int i = 51; i <= 180; i++) drive(1'b1, 1'b0, 1'b0, 8'd5, 8'(i), 8'd0, 1'b0, 1'b0);
      for (int j = 0; j <= 180; j++) drive(1'b1, 1'b0, 1'b0, 8'd5, 8'd0, 8'(j), 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd5, 8'd0, 8'd0, 1'b0, 1'b1);
      for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 1'b0, 8'd5, 8'(i), 8'd0, 1'b0, 1'b0);
      for (int j = 0; j <= 5; j++) drive(1'b1, 1'b0, 1'b0, 8'd5, 8'd0, 8'(j), 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd5, 8'd0, 8'd0, 1'b0, 1'b1);

      // clr at step 50 restarts immediately with top 5
      drive(1'b1, 1'b1, 1'b0, 8'd180, 8'd0, 8'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 50; i++) drive(1'b1, 1'b0, 1'b0, 8'd180, 8'(i), 8'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 1'b0, 8'd5, 8'(i), 8'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd5, 8'd0, 8'd0, 1'b1, 1'b0);

      // top 0: phase toggles every enabled cycle, wrap every second
      drive(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
         drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
      end

      // top all-ones: wraps via compare at 255
      drive(1'b1, 1'b1, 1'b0, 8'd255, 8'd0, 8'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 255; i++) drive(1'b1, 1'b0, 1'b0, 8'd255, 8'(i), 8'd0, 1'b0, 1'b0);
      for (int j = 0; j <= 255; j++) drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'(j), 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0);

      // Async reset in phase B, between edges; afterwards top is 180 not top_in
      drive(1'b1, 1'b1, 1'b0, 8'd10, 8'd0, 8'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) drive(1'b1, 1'b0, 1'b0, 8'd10, 8'(i), 8'd0, 1'b0, 1'b0);
      for (int j = 0; j <= 3; j++) drive(1'b1, 1'b0, 1'b0, 8'd10, 8'd0, 8'(j), 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 8'd10, 8'd0, 8'd3, 1'b1, 1'b0);
      drain();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", {cnt_h, cnt_l, phase, wrap}, 18'd0);
      @(negedge clk);
      chk("reset_held", {cnt_h, cnt_l, phase, wrap}, 18'd0);
      rst_n = 1'b1;
      for (int i = 1; i <= 180; i++) drive(1'b1, 1'b0, 1'b0, 8'd10, 8'(i), 8'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd10, 8'd0, 8'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd10, 8'd0, 8'd1, 1'b1, 1'b0);

      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
